// File: rtl/adder_sched_pkg.sv
// Shared types and sizing constants for the round-robin adder scheduler.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_BITS  = 32'sd8;
  localparam int DEF_N_REQ = 32'sd4;

  function automatic int id_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  localparam int DEF_ID_W = id_width(DEF_N_REQ);

endpackage

// File: rtl/adder_sched_adder.sv
// Shared combinational adder; the carry out is intentionally dropped.
module adder_sched_adder #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] a_in,
  input  logic [BITS-1:0] b_in,
  output logic [BITS-1:0] sum
);

  assign sum = a_in + b_in;

endmodule

// File: rtl/adder_sched.sv
// Round-robin arbiter in front of one shared adder: IDLE grants, CALC adds,
// RESP holds the registered result until the consumer takes it.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [N_REQ-1:0]              req_val,
  input  logic [N_REQ*BITS-1:0]         req_a,
  input  logic [N_REQ*BITS-1:0]         req_b,
  output logic [N_REQ-1:0]              req_rdy,
  output logic                          resp_val,
  input  logic                          resp_rdy,
  output logic [BITS-1:0]               resp_sum,
  output logic [id_width(N_REQ)-1:0]    resp_id,
  output logic [15:0]                   txn_cnt
);

  localparam int ID_W = id_width(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 32'sd1);

  state_e            state_r;
  logic [ID_W-1:0]   last_grant_r;
  logic [ID_W-1:0]   id_r;
  logic [BITS-1:0]   a_r;
  logic [BITS-1:0]   b_r;
  logic              resp_val_r;
  logic [BITS-1:0]   resp_sum_r;
  logic [ID_W-1:0]   resp_id_r;
  logic [15:0]       txn_cnt_r;

  logic              win_found_s;
  logic [ID_W-1:0]   win_idx_s;
  logic [BITS-1:0]   win_a_s;
  logic [BITS-1:0]   win_b_s;
  logic [BITS-1:0]   sum_s;
  logic              xfer_s;
  logic              done_s;
  logic [BITS-1:0]   a_arr_s [N_REQ];
  logic [BITS-1:0]   b_arr_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr_s[g] = req_a[g*BITS +: BITS];
    assign b_arr_s[g] = req_b[g*BITS +: BITS];
  end

  // Winner search: first valid requester walking upward from last_grant+1.
  always_comb begin
    int              c_int;
    logic [ID_W-1:0] cand;
    logic            hit;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    c_int       = 32'sd0;
    cand        = '0;
    hit         = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      c_int       = int'(last_grant_r) + 32'sd1 + k;
      c_int       = (c_int >= N_REQ) ? (c_int - N_REQ) : c_int;
      cand        = ID_W'(c_int);
      hit         = req_val[cand] & ~win_found_s;
      win_idx_s   = hit ? cand : win_idx_s;
      win_found_s = win_found_s | hit;
    end
  end

  assign win_a_s = a_arr_s[win_idx_s];
  assign win_b_s = b_arr_s[win_idx_s];
  assign xfer_s  = (state_r == IDLE) && win_found_s;
  assign done_s  = (state_r == RESP) && resp_rdy;

  // Accept strobe is combinational so a requester sees its grant in the same cycle.
  always_comb begin
    req_rdy = '0;
    if (xfer_s) begin
      req_rdy[win_idx_s] = 1'b1;
    end else begin
      req_rdy = '0;
    end
  end

  adder_sched_adder #(
    .BITS (BITS)
  ) u_adder (
    .a_in (a_r),
    .b_in (b_r),
    .sum  (sum_s)
  );

  // Scheduler FSM; reset drops any in-flight transaction and restores requester 0 priority.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_r      <= IDLE;
      last_grant_r <= LAST_ID;
      id_r         <= '0;
      a_r          <= '0;
      b_r          <= '0;
      resp_val_r   <= 1'b0;
      resp_sum_r   <= '0;
      resp_id_r    <= '0;
      txn_cnt_r    <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            a_r          <= win_a_s;
            b_r          <= win_b_s;
            id_r         <= win_idx_s;
            last_grant_r <= win_idx_s;
            state_r      <= CALC;
          end
        end
        CALC: begin
          resp_sum_r <= sum_s;
          resp_id_r  <= id_r;
          resp_val_r <= 1'b1;
          state_r    <= RESP;
        end
        RESP: begin
          if (done_s) begin
            resp_val_r <= 1'b0;
            txn_cnt_r  <= txn_cnt_r + 16'd1;
            state_r    <= IDLE;
          end
        end
        default: begin
          resp_val_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign resp_val = resp_val_r;
  assign resp_sum = resp_sum_r;
  assign resp_id  = resp_id_r;
  assign txn_cnt  = txn_cnt_r;

endmodule

// File: tb/tb_adder_sched.sv
// Self-checking bench for adder_sched: directed scenarios plus randomized
// traffic against a transaction-level round-robin model.
module tb_adder_sched;

  localparam int BITS = 8;
  localparam int N    = 4;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [N-1:0]      req_val;
  logic [N*BITS-1:0] req_a;
  logic [N*BITS-1:0] req_b;
  logic [N-1:0]      req_rdy;
  logic              resp_val;
  logic              resp_rdy;
  logic [BITS-1:0]   resp_sum;
  logic [1:0]        resp_id;
  logic [15:0]       txn_cnt;

  adder_sched #(.BITS(BITS), .N_REQ(N)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req_val  (req_val),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_rdy  (req_rdy),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_sum (resp_sum),
    .resp_id  (resp_id),
    .txn_cnt  (txn_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: pending requests, one outstanding transaction at most.
  bit              pend [N];
  logic [BITS-1:0] pa [N];
  logic [BITS-1:0] pb [N];
  int              last_grant;
  bit              busy;
  int              exp_sum, exp_id, resp_due, cyc, last_sum;
  logic [15:0]     exp_cnt;
  int              rdy_mode;
  bit              new_en;
  int              obs_grant[$];
  int              obs_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_val[i] = pend[i];
      req_a[i*BITS +: BITS] = pend[i] ? pa[i] : BITS'($urandom);
      req_b[i*BITS +: BITS] = pend[i] ? pb[i] : BITS'($urandom);
    end
    resp_rdy = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (last_grant + 1 + k) % N;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < N; i++) r |= pend[i];
    return r;
  endfunction

  task automatic step();
    int w;
    bit hs;
    @(negedge wb_clk_i);
    cyc++;
    w  = -1;
    hs = 0;
    for (int i = 0; i < N; i++) begin
      if (req_rdy[i] === 1'b1) begin
        obs_grant.push_back(i);
        obs_cyc.push_back(cyc);
      end
    end
    if (!busy) begin
      w = pick();
      check_val("req_rdy", 32'(req_rdy), (w >= 0) ? (32'd1 << w) : 32'd0);
      check_val("resp_val_idle", 32'(resp_val), 32'd0);
    end else begin
      check_val("req_rdy_busy", 32'(req_rdy), 32'd0);
      if (cyc >= resp_due) begin
        check_val("resp_val", 32'(resp_val), 32'd1);
        check_val("resp_sum", 32'(resp_sum), 32'(exp_sum));
        check_val("resp_id", 32'(resp_id), 32'(exp_id));
        hs = resp_rdy;
      end else begin
        check_val("resp_val_calc", 32'(resp_val), 32'd0);
      end
    end
    check_val("txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
    @(posedge wb_clk_i);
    #1;
    if (w >= 0) begin
      busy       = 1;
      exp_sum    = (int'(pa[w]) + int'(pb[w])) % (1 << BITS);
      exp_id     = w;
      last_grant = w;
      resp_due   = cyc + 2;
      pend[w]    = 0;
    end
    if (hs) begin
      busy     = 0;
      exp_cnt  = exp_cnt + 16'd1;
      last_sum = exp_sum;
    end
    if (new_en) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          pa[i]   = BITS'($urandom);
          pb[i]   = BITS'($urandom);
        end
      end
    end
    drive();
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (!busy && !any_pend()) break;
      step();
    end
    check_val("drain_done", 32'(busy || any_pend()), 32'd0);
  endtask

  task automatic model_reset();
    busy       = 0;
    last_grant = N - 1;
    exp_cnt    = 16'd0;
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b0;
    model_reset();
    drive();
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
    check_val({tag, "_resp_val"}, 32'(resp_val), 32'd0);
    check_val({tag, "_resp_sum"}, 32'(resp_sum), 32'd0);
    check_val({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    check_val({tag, "_txn_cnt"}, 32'(txn_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_ord[5];
    exp_ord  = '{0, 1, 2, 3, 0};
    cyc      = 0;
    last_sum = -1;
    rdy_mode = 1;
    new_en   = 0;
    model_reset();
    drive();
    wb_rst_i = 1'b1;
    #1 wb_rst_i = 1'b0;
    #2 check_reset_outputs("rst");
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;

    // Basic transaction from requester 0, grant visible combinationally.
    pend[0] = 1; pa[0] = 8'h12; pb[0] = 8'h34;
    drive();
    #1 check_val("s1_rdy_comb", 32'(req_rdy), 32'h1);
    drain();
    check_val("s1_sum", 32'(last_sum), 32'h46);
    check_val("s1_cnt", 32'(txn_cnt), 32'd1);

    // Carry is dropped.
    pend[2] = 1; pa[2] = 8'hFF; pb[2] = 8'h02;
    drive();
    drain();
    check_val("s2_wrap_sum", 32'(last_sum), 32'h01);

    // All four requesting continuously after reset: fair rotation, 3-cycle spacing.
    do_reset();
    obs_grant.delete();
    obs_cyc.delete();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1; pa[i] = BITS'($urandom); pb[i] = BITS'($urandom);
    end
    drive();
    for (int k = 0; k < 40 && obs_grant.size() < 5; k++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          pend[i] = 1; pa[i] = BITS'($urandom); pb[i] = BITS'($urandom);
        end
      end
      drive();
    end
    check_val("rr_count", 32'(obs_grant.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < obs_grant.size(); k++)
      check_val("rr_order", 32'(obs_grant[k]), 32'(exp_ord[k]));
    for (int k = 1; k < 5 && k < obs_grant.size(); k++)
      check_val("rr_gap", 32'(obs_cyc[k] - obs_cyc[k-1]), 32'd3);
    for (int i = 0; i < N; i++) pend[i] = 0;
    drain();

    // Consumer stalls for five cycles in RESP while another requester waits.
    pend[1] = 1; pa[1] = 8'hA5; pb[1] = 8'h3C;
    rdy_mode = 0;
    drive();
    step();
    pend[0] = 1; pa[0] = 8'h01; pb[0] = 8'h02;
    drive();
    for (int k = 0; k < 6; k++) step();
    rdy_mode = 1;
    drive();
    drain();

    // Reset while in CALC: outputs clear with no edge, then requester 3 served.
    pend[1] = 1; pa[1] = 8'h10; pb[1] = 8'h20;
    drive();
    step();
    pend[1] = 0;
    drive();
    #1 wb_rst_i = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
    obs_grant.delete();
    obs_cyc.delete();
    pend[3] = 1; pa[3] = 8'h0F; pb[3] = 8'h01;
    drive();
    drain();
    check_val("post_rst_grant", (obs_grant.size() > 0) ? 32'(obs_grant[0]) : 32'hFFFF_FFFF, 32'd3);
    check_val("post_rst_sum", 32'(last_sum), 32'h10);
    check_val("post_rst_cnt", 32'(txn_cnt), 32'd1);

    // Randomized traffic with random back-pressure.
    new_en   = 1;
    rdy_mode = 2;
    drive();
    for (int k = 0; k < 300; k++) step();
    new_en   = 0;
    rdy_mode = 1;
    drive();
    drain();

    // Counter wrap from 0xFFFF.
    force dut.txn_cnt_r = 16'hFFFF;
    @(posedge wb_clk_i);
    #1 release dut.txn_cnt_r;
    exp_cnt = 16'hFFFF;
    check_val("preload_cnt", 32'(txn_cnt), 32'h0000_FFFF);
    pend[2] = 1; pa[2] = 8'h05; pb[2] = 8'h06;
    drive();
    drain();
    check_val("cnt_wrap", 32'(txn_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_sched.md
ADDER_SCHED -- requirements
Module: adder_sched

Interface
REQ-001 Parameter BITS, default 8, operand and sum width in bits.
REQ-002 Parameter N_REQ, default 4, number of requesters sharing the adder.
REQ-003 Port wb_clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port wb_rst_i, input, 1, reset: asynchronous assertion, active-low.
REQ-005 Port req_val, input, N_REQ, per-requester operand-valid.
REQ-006 Port req_a, input, N_REQ*BITS, packed operand A; requester i at bits [i*BITS +: BITS].
REQ-007 Port req_b, input, N_REQ*BITS, packed operand B; same packing as req_a.
REQ-008 Port req_rdy, output, N_REQ, per-requester accept strobe.
REQ-009 Port resp_val, output, 1, result valid.
REQ-010 Port resp_rdy, input, 1, consumer ready.
REQ-011 Port resp_sum, output, BITS, result A+B.
REQ-012 Port resp_id, output, clog2(N_REQ), index of the requester that owns the result.
REQ-013 Port txn_cnt, output, 16, count of completed transactions.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and RESP.
REQ-015 In IDLE, the winner SHALL be the first requester with req_val=1, searching upward from (last_grant+1) mod N_REQ.
REQ-016 In IDLE, req_rdy SHALL be one-hot on the winner, combinationally; req_rdy SHALL be all-zero in any other state or when no req_val is set.
REQ-017 A transfer SHALL occur on an edge where req_val[i]=req_rdy[i]=1; on that edge the block latches the winner's A, B and index, sets last_grant to i, and moves to CALC.
REQ-018 In CALC, the latched operands SHALL drive one shared adder instance; at the next edge resp_sum is registered and the FSM moves to RESP.
REQ-019 resp_sum SHALL equal (A+B) mod 2^BITS; any carry out is discarded.
REQ-020 In RESP, resp_val SHALL be 1 and resp_sum and resp_id SHALL hold stable until resp_rdy=1.
REQ-021 On an edge with resp_val=resp_rdy=1, the FSM SHALL return to IDLE and txn_cnt SHALL increment, wrapping from 0xFFFF to 0x0000.
REQ-022 Latency SHALL be: transfer at edge t gives resp_val=1 from edge t+2. Peak throughput SHALL be one transaction per 3 cycles.
REQ-023 Requesters that are not granted SHALL NOT lose their requests; they are expected to hold req_val and operands until their req_rdy.
REQ-024 req_val changes outside IDLE SHALL have no effect on the latched operands.
REQ-025 resp_val SHALL be 0 in IDLE and in CALC.

Reset
REQ-026 With wb_rst_i=0, the block SHALL asynchronously enter IDLE with last_grant=N_REQ-1, so requester 0 has first priority after reset.
REQ-027 Reset values SHALL be: resp_val=0, resp_sum=0, resp_id=0, txn_cnt=0, req_rdy=0.
REQ-028 Reset asserted in CALC or RESP SHALL discard the in-flight transaction without incrementing txn_cnt.
REQ-029 Reset release SHALL be synchronised externally; the block SHALL be able to accept a request at the first edge after release.

Structure
REQ-030 Package adder_sched_pkg SHALL hold the state enum (IDLE, CALC, RESP), the default BITS and N_REQ values, and the width constant for resp_id.
REQ-031 The existing combinational adder module SHALL be instantiated exactly once as the sole sub-module (a_in, b_in, sum). Arbitration and FSM logic SHALL be local to adder_sched.

Verification
REQ-032 Scenario: after reset, req_val=0001, A0=0x12, B0=0x34 -> req_rdy=0001 in the same cycle; resp_val=1 two edges later with resp_sum=0x46, resp_id=0; txn_cnt=1 after handshake.
REQ-033 Scenario: A=0xFF, B=0x02 -> resp_sum=0x01 (wrap, carry dropped).
REQ-034 Scenario: req_val=1111 held with resp_rdy=1 -> grants follow the order 0,1,2,3,0; one grant every 3 cycles; no requester is starved.
REQ-035 Scenario: resp_rdy=0 for 5 cycles in RESP -> resp_val, resp_sum and resp_id remain stable; req_rdy=0000 throughout; txn_cnt unchanged until the handshake.
REQ-036 Scenario: wb_rst_i pulled low during CALC -> outputs return to their reset values immediately with no clock edge; txn_cnt=0; the next request from requester 3 is served normally.
REQ-037 Scenario: preload 0xFFFF completions (forced or long run), then one more transaction -> txn_cnt=0x0000.
